// File: rtl/fifo_access_controller.sv
// Shares one capture FIFO between two round-robin writers and one reader, tracking occupancy
// so the FIFO never overflows or underflows, and sequencing a timed clear after reset/request.
module fifo_access_controller #(
    parameter int unsigned FIFO_SIZE    = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CLEAR_CYCLES = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               clear_request,
    input  logic                               wr0_req,
    input  logic [DATA_WIDTH-1:0]              wr0_data,
    output logic                               wr0_grant,
    input  logic                               wr1_req,
    input  logic [DATA_WIDTH-1:0]              wr1_data,
    output logic                               wr1_grant,
    input  logic                               rd_req,
    output logic                               rd_grant,
    output logic                               rd_valid,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               fifo_push,
    output logic                               fifo_pop,
    output logic                               fifo_clear,
    output logic [DATA_WIDTH-1:0]              fifo_wdata,
    input  logic [DATA_WIDTH-1:0]              fifo_rdata,
    output logic [$clog2(FIFO_SIZE+1)-1:0]     level,
    output logic                               full,
    output logic                               empty,
    output logic                               busy
);

    localparam int unsigned LW = $clog2(FIFO_SIZE + 1);
    localparam int unsigned CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [LW-1:0] LevelMax = LW'(FIFO_SIZE);
    localparam logic [CW-1:0] CntLast  = CW'(CLEAR_CYCLES - 1);

    typedef enum logic {StClearing, StRun} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  rr_q, rr_d;
    logic                  clear_q, clear_d;
    logic                  push_q, push_d;
    logic                  pop_q, pop_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_ok;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rr_d       = rr_q;
        clear_d    = 1'b0;
        wdata_d    = wdata_q;
        rd_valid_d = pop_q;
        wr0_grant  = 1'b0;
        wr1_grant  = 1'b0;
        rd_grant   = 1'b0;
        wr_ok      = 1'b0;

        unique case (state_q)
            StClearing: begin
                level_d = '0;
                // First clearing cycle only raises fifo_clear; the counter runs while it is high.
                if (clear_q) begin
                    if (cnt_q == CntLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        clear_d = 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    clear_d = 1'b1;
                end
            end
            StRun: begin
                if (clear_request) begin
                    state_d    = StClearing;
                    level_d    = '0;
                    rd_valid_d = 1'b0;
                end else if (enable) begin
                    rd_grant = rd_req && (level_q != '0);
                    wr_ok    = (level_q != LevelMax) || rd_grant;
                    if (wr_ok) begin
                        if (wr0_req && wr1_req) begin
                            wr0_grant = rr_q;
                            wr1_grant = !rr_q;
                        end else begin
                            wr0_grant = wr0_req;
                            wr1_grant = wr1_req;
                        end
                    end
                    if (wr0_grant) begin
                        rr_d    = 1'b0;
                        wdata_d = wr0_data;
                    end else if (wr1_grant) begin
                        rr_d    = 1'b1;
                        wdata_d = wr1_data;
                    end
                    if ((wr0_grant || wr1_grant) && !rd_grant) begin
                        level_d = level_q + LW'(1);
                    end else if (!(wr0_grant || wr1_grant) && rd_grant) begin
                        level_d = level_q - LW'(1);
                    end
                end
            end
            default: state_d = StClearing;
        endcase

        push_d = wr0_grant || wr1_grant;
        pop_d  = rd_grant;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StClearing;
            cnt_q      <= '0;
            level_q    <= '0;
            rr_q       <= 1'b1;
            clear_q    <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rr_q       <= rr_d;
            clear_q    <= clear_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            rd_valid_q <= rd_valid_d;
            wdata_q    <= wdata_d;
        end
    end

    assign fifo_push  = push_q;
    assign fifo_pop   = pop_q;
    assign fifo_clear = clear_q;
    assign fifo_wdata = wdata_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = fifo_rdata;
    assign level      = level_q;
    assign full       = (level_q == LevelMax);
    assign empty      = (level_q == '0);
    assign busy       = (state_q == StClearing);

endmodule

// File: doc/fifo_access_controller.md
Name: fifo_access_controller

Overview:
- Sequences and shares a single capture FIFO between two pixel-stream writers and one reader.
- Round-robin arbitrates the writers and gates push/pop against an internal occupancy count, so the FIFO never overflows or underflows.
- Runs a timed clear sequence on the FIFO after reset and on request.
- Sits between the camera capture front-ends and the frame-transfer logic, on one clock domain.

Parameters:
- FIFO_SIZE, 8, depth of the controlled FIFO in words (>= 2).
- DATA_WIDTH, 32, word width.
- CLEAR_CYCLES, 8, number of cycles fifo_clear is held high during a clear sequence (>= 1).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 = no new grants or pops issued; all state held.
- clear_request  in  1  pulse; starts a clear sequence.
- wr0_req  in  1  writer 0 wants to push.
- wr0_data  in  DATA_WIDTH  writer 0 word.
- wr0_grant  out  1  combinational; writer 0 word accepted this edge.
- wr1_req  in  1  writer 1 wants to push.
- wr1_data  in  DATA_WIDTH  writer 1 word.
- wr1_grant  out  1  combinational; writer 1 word accepted this edge.
- rd_req  in  1  reader wants a word.
- rd_grant  out  1  combinational; pop accepted this edge.
- rd_valid  out  1  registered; rd_data valid.
- rd_data  out  DATA_WIDTH  forwarded fifo_rdata.
- fifo_push  out  1  registered push strobe to the FIFO.
- fifo_pop  out  1  registered pop strobe to the FIFO.
- fifo_clear  out  1  registered clear to the FIFO.
- fifo_wdata  out  DATA_WIDTH  registered push data.
- fifo_rdata  in  DATA_WIDTH  FIFO output, valid the cycle after fifo_pop.
- level  out  $clog2(FIFO_SIZE+1)  occupancy count.
- full  out  1  level == FIFO_SIZE.
- empty  out  1  level == 0.
- busy  out  1  high while in CLEARING.

Behaviour:
- Reset values: state = CLEARING, clear counter = 0, level = 0, empty = 1, full = 0, busy = 1, fifo_clear = 0, fifo_push = 0, fifo_pop = 0, fifo_wdata = 0, rd_valid = 0, rr_last = 1 (writer 0 wins the first tie).
- Reset mid-operation aborts everything; any in-flight push, pop or rd_valid is dropped.
- FSM states: CLEARING and RUN.
- CLEARING:
  - fifo_clear = 1 for exactly CLEAR_CYCLES cycles; the counter counts 0..CLEAR_CYCLES-1.
  - On the final count, go to RUN; fifo_clear falls on the RUN entry edge.
  - No grants; level forced to 0; clear_request ignored.
- RUN, write arbitration:
  - Grants are combinational and require enable = 1.
  - A write grant also requires level < FIFO_SIZE, or a pop granted in the same cycle.
  - If only one writer requests, it is granted.
  - If both request, the writer not equal to rr_last is granted; rr_last updates to the granted writer.
  - At most one write grant per cycle.
- RUN, read:
  - rd_grant = enable & rd_req & (level > 0).
  - A read cannot use a write from the same cycle; the word must already be counted in level.
- Latency:
  - Grant edge N: fifo_push/fifo_pop and fifo_wdata registered, high during cycle N+1 for one cycle.
  - The FIFO captures the push at edge N+1.
  - fifo_rdata is valid during N+2; rd_valid is high during N+2 for one cycle, with rd_data = fifo_rdata.
  - Back-to-back grants give back-to-back strobes.
- level update at the grant edge:
  - +1 on a write grant alone.
  - -1 on a read grant alone.
  - Unchanged when both occur.
  - Never wraps: saturation is prevented by the grant rules.
- clear_request in RUN:
  - Next state is CLEARING and level becomes 0.
  - No grants in the request cycle.
  - Strobes already registered still issue.
  - A pending rd_valid is suppressed.
- enable = 0: no grants; strobes already in flight complete; level, rr_last and state are held.
- The CLEARING sequence runs regardless of enable.

Test Plan:
- Reset 1 cycle, then idle -> fifo_clear high for exactly 8 cycles, busy falls with it, level = 0, empty = 1.
- wr0_req continuous with data 0x100+i, no reads -> 8 grants, fifo_push pulses one cycle after each grant; wr0_grant = 0 once level = 8, full = 1.
- wr0_req and wr1_req both held, then 4 reads -> grants alternate w0,w1,w0,w1 after reset; rd_valid arrives 2 cycles after each rd_grant with data in push order.
- Full FIFO, wr1_req and rd_req in the same cycle -> both granted, level stays 8, fifo_push and fifo_pop pulse together.
- level = 3, clear_request pulse with rd_grant in the previous cycle -> that rd_valid suppressed, level = 0, fifo_clear high 8 cycles, no grants until RUN.
- Empty FIFO with rd_req = 1 -> no rd_grant. Assert reset during CLEARING -> counter restarts and clear lasts a full 8 cycles.
